// File: rtl/stream_comparator.sv
// stream_comparator: one-deep pipelined magnitude comparator with a
// valid/ready handshake on both sides and optional per-result statistics.
// Each accepted operand pair (a, b, signed_mode) produces one registered
// one-hot result {x: a<b, y: a==b, z: a>b} one cycle later.
// Optional feature macro: CMP_STATS_EN. When defined, lt_cnt/eq_cnt/gt_cnt
// count transferred results (saturating, cleared by clr_cnt). When
// undefined, the counters are tied to zero and clr_cnt is ignored.
module stream_comparator #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             signed_mode,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             x,
  output logic             y,
  output logic             z,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] lt_cnt,
  output logic [CNT_W-1:0] eq_cnt,
  output logic [CNT_W-1:0] gt_cnt
);

  // Output-register occupancy states.
  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  logic [0:0]     r_state;
  logic [0:0]     w_state_nxt;
  logic           r_x;
  logic           r_y;
  logic           r_z;
  logic           w_in_xfer;
  logic           w_out_xfer;
  logic [WIDTH:0] w_a_ext;
  logic [WIDTH:0] w_b_ext;
  logic           w_lt;
  logic           w_eq;
  logic           w_gt;

  // Handshake: the output register can take a new result when it is empty
  // or being drained in the same cycle.
  assign out_valid  = (r_state == ST_FULL);
  assign in_ready   = !out_valid || out_ready;
  assign w_in_xfer  = in_valid && in_ready;
  assign w_out_xfer = out_valid && out_ready;

  // One extra bit lets a single signed compare cover both modes: sign-extend
  // in signed mode, zero-extend in unsigned mode.
  assign w_a_ext = {signed_mode & a[WIDTH-1], a};
  assign w_b_ext = {signed_mode & b[WIDTH-1], b};
  assign w_lt    = ($signed(w_a_ext) < $signed(w_b_ext));
  assign w_eq    = (a == b);
  assign w_gt    = !w_lt && !w_eq;

  assign x = r_x;
  assign y = r_y;
  assign z = r_z;

  // Next-state decode for the EMPTY/FULL output register.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_EMPTY: begin
        if (w_in_xfer) begin
          w_state_nxt = ST_FULL;
        end else begin
          w_state_nxt = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (w_out_xfer && !w_in_xfer) begin
          w_state_nxt = ST_EMPTY;
        end else begin
          w_state_nxt = ST_FULL;
        end
      end
      default: begin
        w_state_nxt = ST_EMPTY;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Result register: load on accept, clear when drained, hold on stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_x <= 1'b0;
      r_y <= 1'b0;
      r_z <= 1'b0;
    end else if (w_in_xfer) begin
      r_x <= w_lt;
      r_y <= w_eq;
      r_z <= w_gt;
    end else if (w_out_xfer) begin
      r_x <= 1'b0;
      r_y <= 1'b0;
      r_z <= 1'b0;
    end
  end

`ifdef CMP_STATS_EN
  logic [CNT_W-1:0] r_lt_cnt;
  logic [CNT_W-1:0] r_eq_cnt;
  logic [CNT_W-1:0] r_gt_cnt;

  // Saturating increment: stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == {CNT_W{1'b1}}) begin
      sat_inc = v;
    end else begin
      sat_inc = v + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  endfunction

  // Statistics: clear wins over a same-cycle count of a drained result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lt_cnt <= {CNT_W{1'b0}};
      r_eq_cnt <= {CNT_W{1'b0}};
      r_gt_cnt <= {CNT_W{1'b0}};
    end else if (clr_cnt) begin
      r_lt_cnt <= {CNT_W{1'b0}};
      r_eq_cnt <= {CNT_W{1'b0}};
      r_gt_cnt <= {CNT_W{1'b0}};
    end else if (w_out_xfer) begin
      if (r_x) begin
        r_lt_cnt <= sat_inc(r_lt_cnt);
      end
      if (r_y) begin
        r_eq_cnt <= sat_inc(r_eq_cnt);
      end
      if (r_z) begin
        r_gt_cnt <= sat_inc(r_gt_cnt);
      end
    end
  end

  assign lt_cnt = r_lt_cnt;
  assign eq_cnt = r_eq_cnt;
  assign gt_cnt = r_gt_cnt;
`else
  // Statistics compiled out; clr_cnt has no effect.
  logic w_unused_clr_cnt;
  assign w_unused_clr_cnt = clr_cnt;
  assign lt_cnt = {CNT_W{1'b0}};
  assign eq_cnt = {CNT_W{1'b0}};
  assign gt_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_stream_comparator.sv
// Directed, table-driven bench for stream_comparator (WIDTH=8, CNT_W=3).
module tb_stream_comparator;

`ifdef CMP_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif
  localparam int CMAX = 7;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] a = 8'h00;
  logic [7:0] b = 8'h00;
  logic       signed_mode = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic       x, y, z;
  logic       clr_cnt = 1'b0;
  logic [2:0] lt_cnt, eq_cnt, gt_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  // model state
  logic m_valid = 1'b0, m_x = 1'b0, m_y = 1'b0, m_z = 1'b0;
  int   m_lt = 0, m_eq = 0, m_gt = 0;

  typedef struct {
    logic [7:0] a, b;
    logic sm, iv, ordy, clr;
    logic ir, v, x, y, z;
  } vec_t;

  stream_comparator #(.WIDTH(8), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .signed_mode(signed_mode),
    .in_valid(in_valid), .in_ready(in_ready), .out_valid(out_valid),
    .out_ready(out_ready), .x(x), .y(y), .z(z), .clr_cnt(clr_cnt),
    .lt_cnt(lt_cnt), .eq_cnt(eq_cnt), .gt_cnt(gt_cnt)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic [7:0] fa, input logic [7:0] fb,
                              input logic sm, input logic iv, input logic ordy,
                              input logic clr, input logic ir, input logic v,
                              input logic ex, input logic ey, input logic ez);
    vec_t r;
    r.a = fa; r.b = fb; r.sm = sm; r.iv = iv; r.ordy = ordy; r.clr = clr;
    r.ir = ir; r.v = v; r.x = ex; r.y = ey; r.z = ez;
    return r;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_cnts(input string tag);
    chk({tag, " lt_cnt"}, int'(lt_cnt), STATS ? m_lt : 0);
    chk({tag, " eq_cnt"}, int'(eq_cnt), STATS ? m_eq : 0);
    chk({tag, " gt_cnt"}, int'(gt_cnt), STATS ? m_gt : 0);
  endtask

  function automatic int sat(input int v);
    return (v >= CMAX) ? CMAX : v + 1;
  endfunction

  // Called at posedge+1: drive a row, check in_ready, clock, check outputs.
  task automatic apply(input vec_t v, input string tag);
    logic xfer;
    a = v.a; b = v.b; signed_mode = v.sm; in_valid = v.iv;
    out_ready = v.ordy; clr_cnt = v.clr;
    #1;
    chk({tag, " in_ready"}, int'(in_ready), int'(v.ir));
    xfer = m_valid && v.ordy;
    @(posedge clk);
    #1;
    if (v.clr) begin
      m_lt = 0; m_eq = 0; m_gt = 0;
    end else if (xfer) begin
      if (m_x) m_lt = sat(m_lt);
      if (m_y) m_eq = sat(m_eq);
      if (m_z) m_gt = sat(m_gt);
    end
    m_valid = v.v; m_x = v.x; m_y = v.y; m_z = v.z;
    chk({tag, " out_valid"}, int'(out_valid), int'(v.v));
    chk({tag, " xyz"}, int'({x, y, z}), int'({v.x, v.y, v.z}));
    chk_cnts(tag);
  endtask

  vec_t tbl[20];
  vec_t sat_tbl[13];

  initial begin
    // main function table
    tbl[0]  = mk(8'hF0, 8'h0F, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    tbl[1]  = mk(8'hF0, 8'h0F, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    tbl[2]  = mk(8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tbl[3]  = mk(8'hFF, 8'hFF, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    tbl[4]  = mk(8'hFF, 8'hFF, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    tbl[5]  = mk(8'hFF, 8'hFF, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    tbl[6]  = mk(8'hFF, 8'hFF, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    tbl[7]  = mk(8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tbl[8]  = mk(8'd3,  8'd9,  1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    tbl[9]  = mk(8'd9,  8'd3,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    tbl[10] = mk(8'd9,  8'd3,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    tbl[11] = mk(8'd9,  8'd3,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    tbl[12] = mk(8'd9,  8'd3,  1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    tbl[13] = mk(8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    tbl[14] = mk(8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tbl[15] = mk(8'h80, 8'h7F, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    tbl[16] = mk(8'h80, 8'h7F, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    tbl[17] = mk(8'h01, 8'hFF, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    tbl[18] = mk(8'h01, 8'hFF, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    tbl[19] = mk(8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    // saturation then clear-with-transfer
    for (int i = 0; i < 9; i++)
      sat_tbl[i] = mk(8'd5, 8'd1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    sat_tbl[9]  = mk(8'd0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    sat_tbl[10] = mk(8'd1, 8'd5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    sat_tbl[11] = mk(8'd5, 8'd1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    sat_tbl[12] = mk(8'd0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // reset state, checked while rst is held
    #12;
    chk("rst out_valid", int'(out_valid), 0);
    chk("rst xyz", int'({x, y, z}), 0);
    chk("rst in_ready", int'(in_ready), 1);
    chk_cnts("rst");
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < 20; i++) apply(tbl[i], $sformatf("main[%0d]", i));

    for (int i = 0; i < 13; i++) begin
      apply(sat_tbl[i], $sformatf("sat[%0d]", i));
      if (i == 9) chk("saturated gt_cnt", int'(gt_cnt), STATS ? CMAX : 0);
      if (i == 11) chk("clr all zero", int'({lt_cnt, eq_cnt, gt_cnt}), 0);
    end

    // mid-stall reset: load an equal pair, stall, then pulse rst
    apply(mk(8'd2, 8'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0), "stall0");
    apply(mk(8'd4, 8'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0), "stall1");
    rst = 1'b1;
    #1;
    chk("midrst out_valid", int'(out_valid), 0);
    chk("midrst xyz", int'({x, y, z}), 0);
    chk("midrst in_ready", int'(in_ready), 1);
    m_valid = 1'b0; m_x = 1'b0; m_y = 1'b0; m_z = 1'b0;
    m_lt = 0; m_eq = 0; m_gt = 0;
    chk_cnts("midrst");
    #1;
    rst = 1'b0;
    apply(mk(8'd7, 8'd2, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1), "post0");
    apply(mk(8'd0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0), "post1");
    chk("post eq_cnt not counted", int'(eq_cnt), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/stream_comparator.md
STREAM_COMPARATOR -- requirements
Module: stream_comparator

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand width in bits (minimum 1).
REQ-002 The block SHALL have parameter CNT_W, default 16, giving the width of each statistics counter (minimum 1).
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset: clk input 1 (rising-edge clock), then rst input 1 (asynchronous active-high reset).
REQ-004 Operand ports SHALL be: a input WIDTH (operand A); b input WIDTH (operand B); signed_mode input 1 (1 = two's-complement compare, 0 = unsigned compare).
REQ-005 Input handshake ports SHALL be: in_valid input 1 (a, b and signed_mode are valid); in_ready output 1 (block can accept an operand pair).
REQ-006 Output handshake ports SHALL be: out_valid output 1 (result is valid); out_ready input 1 (consumer accepts the result).
REQ-007 Result ports SHALL be: x output 1 (a<b); y output 1 (a==b); z output 1 (a>b).
REQ-008 Statistics ports SHALL be: clr_cnt input 1 (synchronous counter clear); lt_cnt, eq_cnt and gt_cnt, each output CNT_W (count of transferred a<b, a==b and a>b results).

Function
REQ-009 An input transfer SHALL occur on a rising clk edge when in_valid and in_ready are both 1; signed_mode SHALL be sampled with a and b.
REQ-010 in_ready SHALL equal (!out_valid || out_ready), combinationally.
REQ-011 Latency SHALL be one cycle: after an input transfer, out_valid=1 and x/y/z SHALL be registered from the next edge.
REQ-012 While out_valid=1, exactly one of x, y, z SHALL be 1; while out_valid=0, x=y=z=0.
REQ-013 An output transfer SHALL occur on an edge when out_valid and out_ready are both 1.
REQ-014 On an output transfer without a simultaneous input transfer, out_valid SHALL go to 0 at that edge.
REQ-015 On a simultaneous output and input transfer, out_valid SHALL stay 1 and the new result SHALL load at that edge, allowing one result per cycle.
REQ-016 While out_valid=1 and out_ready=0 (stall), x, y, z and out_valid SHALL hold their values and in_ready SHALL be 0.
REQ-017 The block SHALL have the following states:
- EMPTY: out_valid=0.
- FULL: out_valid=1.
- EMPTY->FULL on an input transfer.
- FULL->EMPTY on an output transfer with no input transfer.
- FULL->FULL on a stall, or on a simultaneous output and input transfer.
REQ-018 With signed_mode=1, a and b SHALL be compared as WIDTH-bit two's complement.
REQ-019 With signed_mode=0, a and b SHALL be compared as WIDTH-bit unsigned.
REQ-020 On each output transfer, the counter that matches the transferred result SHALL increment by 1.
REQ-021 Each counter SHALL saturate at 2^CNT_W-1 and SHALL NOT wrap.
REQ-022 clr_cnt=1 SHALL zero all three counters at the edge and SHALL take priority over a simultaneous increment, so that transfer is not counted.
REQ-023 clr_cnt SHALL NOT affect the datapath or the handshake.

Reset
REQ-024 While rst=1, the block SHALL immediately force: out_valid=0, x=y=z=0, and lt_cnt=eq_cnt=gt_cnt=0.
REQ-025 While rst=1, in_ready SHALL be 1, since it follows REQ-010 with out_valid=0.
REQ-026 Asserting rst during a stall SHALL discard the pending result, which SHALL NOT be counted.
REQ-027 After rst deasserts, the first rising edge SHALL accept input normally.

Configuration
REQ-028 Macro CMP_STATS_EN defined: the counters SHALL behave per REQ-020 to REQ-022.
REQ-029 Macro CMP_STATS_EN undefined: the counter logic SHALL be compiled out; lt_cnt, eq_cnt and gt_cnt SHALL be tied to 0, clr_cnt SHALL be ignored, and all ports SHALL remain present.

Verification (WIDTH=8 unless stated)
REQ-030 Unsigned compare: a=8'hF0, b=8'h0F, signed_mode=0, in_valid=1, out_ready=1 -> at the next edge out_valid=1, z=1, x=y=0, and gt_cnt=1 one edge later.
REQ-031 Signed compare: the same operands with signed_mode=1 -> x=1, since -16 < 15.
REQ-032 Equal operands and streaming: a=b=8'hFF for 4 consecutive cycles with out_ready=1 -> out_valid=1 continuously with y=1, in_ready=1 throughout, and eq_cnt=4.
REQ-033 Backpressure: accept a=3, b=9, then hold out_ready=0 for 3 cycles while presenting a=9, b=3 -> x=1 held, in_ready=0, and the second pair is not taken; raise out_ready -> the second pair is accepted that edge and z=1 appears on the next edge.
REQ-034 Saturation and clear with CNT_W=2: 5 gt transfers -> gt_cnt=3; then clr_cnt=1 together with a transfer -> all counters are 0.
REQ-035 Mid-stall reset: pulse rst during a stall -> out_valid=0 immediately, counters 0, and the next input transfer produces a normal result.
